// File: rtl/pipe_stage_regs_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_regs_if
// Bundle of every signal exchanged between the pipeline register chain and the
// surrounding datapath/controller of the 5-stage MIPS core.
//   master : datapath/controller side (drives stage inputs, reads stage regs)
//   slave  : pipe_stage_regs (reads stage inputs, drives stage regs)
// Parameters: DW = datapath/instruction width, RW = register index width.
// Optional: PIPE_PERF_EN adds stall_cnt / flush_cnt / bubble_cnt.
// -----------------------------------------------------------------------------
interface pipe_stage_regs_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  // controller commands
  logic          IF_ID_Write;
  logic          IF_Flush;
  logic          ChSel;

  // IF stage
  logic [DW-1:0] if_inst;
  logic [DW-1:0] if_pc4;
  logic [DW-1:0] IF_ID_Inst;
  logic [DW-1:0] IF_ID_PC4;

  // ID stage
  logic          ALUSrc;
  logic          RegDst;
  logic          MemWrite;
  logic          MemRead;
  logic          MemToReg;
  logic          RegWrite;
  logic [2:0]    ALUOperation;
  logic [DW-1:0] id_rd1;
  logic [DW-1:0] id_rd2;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] Rs;
  logic [RW-1:0] Rt;
  logic [RW-1:0] Rd;

  logic          ID_EX_ALUSrc;
  logic          ID_EX_RegDst;
  logic          ID_EX_MemWrite;
  logic          ID_EX_MemRead;
  logic          ID_EX_MemToReg;
  logic          ID_EX_RegWrite;
  logic [2:0]    ID_EX_ALUOperation;
  logic [DW-1:0] ID_EX_rd1;
  logic [DW-1:0] ID_EX_rd2;
  logic [DW-1:0] ID_EX_imm;
  logic [RW-1:0] ID_EX_Rs;
  logic [RW-1:0] ID_EX_Rt;
  logic [RW-1:0] ID_EX_Rd;

  // EX stage
  logic [DW-1:0] ex_alu_res;
  logic [DW-1:0] ex_wdata;
  logic [RW-1:0] ex_wreg;

  logic          EX_MEM_RegWrite;
  logic          EX_MEM_MemRead;
  logic          EX_MEM_MemWrite;
  logic          EX_MEM_MemToReg;
  logic [RW-1:0] EX_MEM_Rd;
  logic [DW-1:0] EX_MEM_ALURes;
  logic [DW-1:0] EX_MEM_WData;

  // MEM stage
  logic [DW-1:0] mem_rdata;

  logic          MEM_WB_RegWrite;
  logic          MEM_WB_MemToReg;
  logic [RW-1:0] MEM_WB_Rd;
  logic [DW-1:0] MEM_WB_ALURes;
  logic [DW-1:0] MEM_WB_RData;

`ifdef PIPE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;
  logic [31:0]   bubble_cnt;
`endif

  modport master (
    output IF_ID_Write, IF_Flush, ChSel,
    output if_inst, if_pc4,
    output ALUSrc, RegDst, MemWrite, MemRead, MemToReg, RegWrite, ALUOperation,
    output id_rd1, id_rd2, id_imm, Rs, Rt, Rd,
    output ex_alu_res, ex_wdata, ex_wreg,
    output mem_rdata,
    input  IF_ID_Inst, IF_ID_PC4,
    input  ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_MemWrite, ID_EX_MemRead,
    input  ID_EX_MemToReg, ID_EX_RegWrite, ID_EX_ALUOperation,
    input  ID_EX_rd1, ID_EX_rd2, ID_EX_imm, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
    input  EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg,
    input  EX_MEM_Rd, EX_MEM_ALURes, EX_MEM_WData,
`ifdef PIPE_PERF_EN
    input  stall_cnt, flush_cnt, bubble_cnt,
`endif
    input  MEM_WB_RegWrite, MEM_WB_MemToReg, MEM_WB_Rd, MEM_WB_ALURes, MEM_WB_RData
  );

  modport slave (
    input  IF_ID_Write, IF_Flush, ChSel,
    input  if_inst, if_pc4,
    input  ALUSrc, RegDst, MemWrite, MemRead, MemToReg, RegWrite, ALUOperation,
    input  id_rd1, id_rd2, id_imm, Rs, Rt, Rd,
    input  ex_alu_res, ex_wdata, ex_wreg,
    input  mem_rdata,
    output IF_ID_Inst, IF_ID_PC4,
    output ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_MemWrite, ID_EX_MemRead,
    output ID_EX_MemToReg, ID_EX_RegWrite, ID_EX_ALUOperation,
    output ID_EX_rd1, ID_EX_rd2, ID_EX_imm, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
    output EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg,
    output EX_MEM_Rd, EX_MEM_ALURes, EX_MEM_WData,
`ifdef PIPE_PERF_EN
    output stall_cnt, flush_cnt, bubble_cnt,
`endif
    output MEM_WB_RegWrite, MEM_WB_MemToReg, MEM_WB_Rd, MEM_WB_ALURes, MEM_WB_RData
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// -----------------------------------------------------------------------------
// pipe_stage_regs
// IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.
// The controller commands stall (IF_ID_Write=0), flush (IF_Flush) and bubble
// (ChSel); this block only holds state.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every stage register
//   bus  : pipe_stage_regs_if.slave, all stage inputs and registered outputs
// Optional: define PIPE_PERF_EN to add 32-bit wrapping stall/flush/bubble
// event counters on the interface.
// -----------------------------------------------------------------------------
module pipe_stage_regs #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic              clk,
  input logic              rst,
  pipe_stage_regs_if.slave bus
);

  // IF/ID
  logic [DW-1:0] if_id_inst_q;
  logic [DW-1:0] if_id_pc4_q;

  // ID/EX
  logic          id_ex_alusrc_q;
  logic          id_ex_regdst_q;
  logic          id_ex_memwrite_q;
  logic          id_ex_memread_q;
  logic          id_ex_memtoreg_q;
  logic          id_ex_regwrite_q;
  logic [2:0]    id_ex_aluop_q;
  logic [DW-1:0] id_ex_rd1_q;
  logic [DW-1:0] id_ex_rd2_q;
  logic [DW-1:0] id_ex_imm_q;
  logic [RW-1:0] id_ex_rs_q;
  logic [RW-1:0] id_ex_rt_q;
  logic [RW-1:0] id_ex_rd_q;

  // EX/MEM
  logic          ex_mem_regwrite_q;
  logic          ex_mem_memread_q;
  logic          ex_mem_memwrite_q;
  logic          ex_mem_memtoreg_q;
  logic [RW-1:0] ex_mem_rd_q;
  logic [DW-1:0] ex_mem_alures_q;
  logic [DW-1:0] ex_mem_wdata_q;

  // MEM/WB
  logic          mem_wb_regwrite_q;
  logic          mem_wb_memtoreg_q;
  logic [RW-1:0] mem_wb_rd_q;
  logic [DW-1:0] mem_wb_alures_q;
  logic [DW-1:0] mem_wb_rdata_q;

  // flush beats hold
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_inst_q <= '0;
      if_id_pc4_q  <= '0;
    end else if (bus.IF_Flush) begin
      if_id_inst_q <= '0;
      if_id_pc4_q  <= '0;
    end else if (bus.IF_ID_Write) begin
      if_id_inst_q <= bus.if_inst;
      if_id_pc4_q  <= bus.if_pc4;
    end
  end

  // a bubble zeroes only the control bits; data and indices keep flowing so
  // the hazard unit still sees valid Rs/Rt
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_alusrc_q   <= 1'b0;
      id_ex_regdst_q   <= 1'b0;
      id_ex_memwrite_q <= 1'b0;
      id_ex_memread_q  <= 1'b0;
      id_ex_memtoreg_q <= 1'b0;
      id_ex_regwrite_q <= 1'b0;
      id_ex_aluop_q    <= '0;
      id_ex_rd1_q      <= '0;
      id_ex_rd2_q      <= '0;
      id_ex_imm_q      <= '0;
      id_ex_rs_q       <= '0;
      id_ex_rt_q       <= '0;
      id_ex_rd_q       <= '0;
    end else begin
      if (bus.ChSel) begin
        id_ex_alusrc_q   <= 1'b0;
        id_ex_regdst_q   <= 1'b0;
        id_ex_memwrite_q <= 1'b0;
        id_ex_memread_q  <= 1'b0;
        id_ex_memtoreg_q <= 1'b0;
        id_ex_regwrite_q <= 1'b0;
        id_ex_aluop_q    <= '0;
      end else begin
        id_ex_alusrc_q   <= bus.ALUSrc;
        id_ex_regdst_q   <= bus.RegDst;
        id_ex_memwrite_q <= bus.MemWrite;
        id_ex_memread_q  <= bus.MemRead;
        id_ex_memtoreg_q <= bus.MemToReg;
        id_ex_regwrite_q <= bus.RegWrite;
        id_ex_aluop_q    <= bus.ALUOperation;
      end
      id_ex_rd1_q <= bus.id_rd1;
      id_ex_rd2_q <= bus.id_rd2;
      id_ex_imm_q <= bus.id_imm;
      id_ex_rs_q  <= bus.Rs;
      id_ex_rt_q  <= bus.Rt;
      id_ex_rd_q  <= bus.Rd;
    end
  end

  // writes to $0 are dropped here so they never reach the forwarding compare
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_regwrite_q <= 1'b0;
      ex_mem_memread_q  <= 1'b0;
      ex_mem_memwrite_q <= 1'b0;
      ex_mem_memtoreg_q <= 1'b0;
      ex_mem_rd_q       <= '0;
      ex_mem_alures_q   <= '0;
      ex_mem_wdata_q    <= '0;
    end else begin
      ex_mem_regwrite_q <= id_ex_regwrite_q & (bus.ex_wreg != '0);
      ex_mem_memread_q  <= id_ex_memread_q;
      ex_mem_memwrite_q <= id_ex_memwrite_q;
      ex_mem_memtoreg_q <= id_ex_memtoreg_q;
      ex_mem_rd_q       <= bus.ex_wreg;
      ex_mem_alures_q   <= bus.ex_alu_res;
      ex_mem_wdata_q    <= bus.ex_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_regwrite_q <= 1'b0;
      mem_wb_memtoreg_q <= 1'b0;
      mem_wb_rd_q       <= '0;
      mem_wb_alures_q   <= '0;
      mem_wb_rdata_q    <= '0;
    end else begin
      mem_wb_regwrite_q <= ex_mem_regwrite_q;
      mem_wb_memtoreg_q <= ex_mem_memtoreg_q;
      mem_wb_rd_q       <= ex_mem_rd_q;
      mem_wb_alures_q   <= ex_mem_alures_q;
      mem_wb_rdata_q    <= bus.mem_rdata;
    end
  end

  assign bus.IF_ID_Inst         = if_id_inst_q;
  assign bus.IF_ID_PC4          = if_id_pc4_q;
  assign bus.ID_EX_ALUSrc       = id_ex_alusrc_q;
  assign bus.ID_EX_RegDst       = id_ex_regdst_q;
  assign bus.ID_EX_MemWrite     = id_ex_memwrite_q;
  assign bus.ID_EX_MemRead      = id_ex_memread_q;
  assign bus.ID_EX_MemToReg     = id_ex_memtoreg_q;
  assign bus.ID_EX_RegWrite     = id_ex_regwrite_q;
  assign bus.ID_EX_ALUOperation = id_ex_aluop_q;
  assign bus.ID_EX_rd1          = id_ex_rd1_q;
  assign bus.ID_EX_rd2          = id_ex_rd2_q;
  assign bus.ID_EX_imm          = id_ex_imm_q;
  assign bus.ID_EX_Rs           = id_ex_rs_q;
  assign bus.ID_EX_Rt           = id_ex_rt_q;
  assign bus.ID_EX_Rd           = id_ex_rd_q;
  assign bus.EX_MEM_RegWrite    = ex_mem_regwrite_q;
  assign bus.EX_MEM_MemRead     = ex_mem_memread_q;
  assign bus.EX_MEM_MemWrite    = ex_mem_memwrite_q;
  assign bus.EX_MEM_MemToReg    = ex_mem_memtoreg_q;
  assign bus.EX_MEM_Rd          = ex_mem_rd_q;
  assign bus.EX_MEM_ALURes      = ex_mem_alures_q;
  assign bus.EX_MEM_WData       = ex_mem_wdata_q;
  assign bus.MEM_WB_RegWrite    = mem_wb_regwrite_q;
  assign bus.MEM_WB_MemToReg    = mem_wb_memtoreg_q;
  assign bus.MEM_WB_Rd          = mem_wb_rd_q;
  assign bus.MEM_WB_ALURes      = mem_wb_alures_q;
  assign bus.MEM_WB_RData       = mem_wb_rdata_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] bubble_cnt_q;

  // a flushed cycle is not a stall even if IF_ID_Write is low
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (!bus.IF_ID_Write && !bus.IF_Flush) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.IF_Flush)                      flush_cnt_q <= flush_cnt_q + 32'd1;
      if (bus.ChSel)                         bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule
